// File: rtl/img_in_loader.sv
// -----------------------------------------------------------------------------
// img_in_loader
//
// Upstream feeder for the bilinear DSA top. It accepts a framed image on a
// byte stream (valid/ready), parses a 4-byte header (0xA5, W, H, S), and
// writes W*H pixels row-major into the mem_in write port. Once the frame is
// complete and both the core and the mem_out clear logic are idle, it issues
// a one-cycle start pulse.
//
// Optional build macro:
//   IMG_LOADER_CHKSUM_EN - a 1-byte XOR trailer follows the pixels. The XOR
//                          covers every header and pixel byte, magic included.
//                          A mismatch goes to ERR with err_size set, and no
//                          start is issued.
//
// Parameters:
//   AW - mem_in address width (maximum frame is 2**AW pixels)
//   DW - pixel width in bits
//
// Ports:
//   clk_50        system clock
//   rst_n         asynchronous active-low reset
//   s_valid       input byte valid
//   s_data        input byte
//   s_ready       loader accepts a byte this cycle (registered)
//   clear_active  mem_out clear in progress
//   core_busy     core is processing
//   mem_we        mem_in write enable (registered)
//   mem_waddr     mem_in write address (registered)
//   mem_wdata     mem_in write data (registered)
//   in_w / in_h   input dimensions to the core
//   scale_q       scale factor, Q0.8
//   start_pulse   one-cycle start to the core
//   busy          frame load in progress (state is not IDLE and not ERR)
//   err_size      sticky header error flag
// -----------------------------------------------------------------------------
module img_in_loader #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          clk_50,
    input  logic          rst_n,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    input  logic          clear_active,
    input  logic          core_busy,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic [7:0]    in_w,
    output logic [7:0]    in_h,
    output logic [7:0]    scale_q,
    output logic          start_pulse,
    output logic          busy,
    output logic          err_size
);

    localparam logic [7:0]  MAGIC   = 8'hA5;
    // 17 bits so that a 16-bit product can be compared against 2**AW
    // without truncation.
    localparam logic [16:0] MAX_PIX = 17'(1) << AW;

`ifdef IMG_LOADER_CHKSUM_EN
    typedef enum logic [3:0] {
        IDLE, HDR_W, HDR_H, HDR_S, PIX, CHK, WAIT, START, ERR
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE, HDR_W, HDR_H, HDR_S, PIX, WAIT, START, ERR
    } state_t;
`endif

    state_t        state_q, state_d;
    logic          s_ready_q, s_ready_d;
    logic [7:0]    w_sh_q, w_sh_d;
    logic [7:0]    h_sh_q, h_sh_d;
    logic [7:0]    in_w_q, in_w_d;
    logic [7:0]    in_h_q, in_h_d;
    logic [7:0]    scale_reg_q, scale_reg_d;
    logic [AW:0]   pix_cnt_q, pix_cnt_d;
    logic [AW:0]   pix_last_q, pix_last_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_waddr_q, mem_waddr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          err_q, err_d;
    logic          start_q;
    logic [7:0]    chk_q, chk_d;

    logic          hs;
    logic [15:0]   area;
    logic          hdr_bad;

    assign hs   = s_valid & s_ready_q;
    // W and H are already in the shadows when S arrives.
    assign area = 16'(w_sh_q) * 16'(h_sh_q);
    assign hdr_bad = (w_sh_q < 8'd2) || (h_sh_q < 8'd2) || (s_data == 8'd0) ||
                     ({1'b0, area} > MAX_PIX);

    always_comb begin
        state_d     = state_q;
        w_sh_d      = w_sh_q;
        h_sh_d      = h_sh_q;
        in_w_d      = in_w_q;
        in_h_d      = in_h_q;
        scale_reg_d = scale_reg_q;
        pix_cnt_d   = pix_cnt_q;
        pix_last_d  = pix_last_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        chk_d       = chk_q;
        s_ready_d   = 1'b0;

        case (state_q)
            IDLE, ERR: begin
                if (hs && s_data == MAGIC) begin
                    state_d = HDR_W;
                    chk_d   = MAGIC;
                end
            end
            HDR_W: begin
                if (hs) begin
                    w_sh_d  = s_data;
                    chk_d   = chk_q ^ s_data;
                    state_d = HDR_H;
                end
            end
            HDR_H: begin
                if (hs) begin
                    h_sh_d  = s_data;
                    chk_d   = chk_q ^ s_data;
                    state_d = HDR_S;
                end
            end
            HDR_S: begin
                if (hs) begin
                    chk_d = chk_q ^ s_data;
                    if (hdr_bad) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = PIX;
                        in_w_d      = w_sh_q;
                        in_h_d      = h_sh_q;
                        scale_reg_d = s_data;
                        err_d       = 1'b0;
                        pix_cnt_d   = '0;
                        // area >= 4 here, so area-1 never underflows.
                        pix_last_d  = (AW+1)'(area - 16'd1);
                    end
                end
            end
            PIX: begin
                if (hs) begin
                    mem_we_d    = 1'b1;
                    mem_waddr_d = pix_cnt_q[AW-1:0];
                    mem_wdata_d = DW'(s_data);
                    chk_d       = chk_q ^ s_data;
                    pix_cnt_d   = pix_cnt_q + 1'b1;
                    if (pix_cnt_q == pix_last_q) begin
`ifdef IMG_LOADER_CHKSUM_EN
                        state_d = CHK;
`else
                        state_d = WAIT;
`endif
                    end
                end
            end
`ifdef IMG_LOADER_CHKSUM_EN
            CHK: begin
                if (hs) begin
                    if (s_data == chk_q) begin
                        state_d = WAIT;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            WAIT: begin
                if (!clear_active && !core_busy) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready is registered against the state we are about to enter, so
        // it is valid for the whole of that state's first cycle.
        case (state_d)
            IDLE:                     s_ready_d = !core_busy;
            HDR_W, HDR_H, HDR_S, PIX: s_ready_d = 1'b1;
`ifdef IMG_LOADER_CHKSUM_EN
            CHK:                      s_ready_d = 1'b1;
`endif
            ERR:                      s_ready_d = 1'b1;
            default:                  s_ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_ready_q   <= 1'b0;
            w_sh_q      <= '0;
            h_sh_q      <= '0;
            in_w_q      <= '0;
            in_h_q      <= '0;
            scale_reg_q <= 8'h80;
            pix_cnt_q   <= '0;
            pix_last_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            chk_q       <= '0;
        end else begin
            state_q     <= state_d;
            s_ready_q   <= s_ready_d;
            w_sh_q      <= w_sh_d;
            h_sh_q      <= h_sh_d;
            in_w_q      <= in_w_d;
            in_h_q      <= in_h_d;
            scale_reg_q <= scale_reg_d;
            pix_cnt_q   <= pix_cnt_d;
            pix_last_q  <= pix_last_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            // Pulse is registered off the START state: write, WAIT, START,
            // then the pulse.
            start_q     <= (state_q == START);
            chk_q       <= chk_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign mem_we      = mem_we_q;
    assign mem_waddr   = mem_waddr_q;
    assign mem_wdata   = mem_wdata_q;
    assign in_w        = in_w_q;
    assign in_h        = in_h_q;
    assign scale_q     = scale_reg_q;
    assign start_pulse = start_q;
    assign busy        = (state_q != IDLE) && (state_q != ERR);
    assign err_size    = err_q;

endmodule

// File: tb/tb_img_in_loader.sv
// -----------------------------------------------------------------------------
// tb_img_in_loader
//
// Scoreboard bench for img_in_loader. The stimulus process pushes every
// expected mem_in write ({addr,data}) and every expected start_pulse cycle
// into queues; a monitor on the falling clock edge pops and compares whenever
// the DUT presents a write or a start pulse.
// -----------------------------------------------------------------------------
module tb_img_in_loader;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk_50 = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          clear_active;
    logic          core_busy;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [7:0]    in_w;
    logic [7:0]    in_h;
    logic [7:0]    scale_q;
    logic          start_pulse;
    logic          busy;
    logic          err_size;

    img_in_loader #(.AW(AW), .DW(DW)) dut (
        .clk_50      (clk_50),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .clear_active(clear_active),
        .core_busy   (core_busy),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .in_w        (in_w),
        .in_h        (in_h),
        .scale_q     (scale_q),
        .start_pulse (start_pulse),
        .busy        (busy),
        .err_size    (err_size)
    );

    always #10 clk_50 = ~clk_50;

    int cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int hs_cyc = 0;

    logic [AW+DW-1:0] wr_q[$];
    int               start_q[$];

    // Monitor: compare every write and every start pulse against the queues.
    always @(negedge clk_50) begin
        if (rst_n === 1'b1) begin
            if (mem_we === 1'b1) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got addr=%0d data=%02h, required no write",
                             mem_waddr, mem_wdata);
                end else begin
                    logic [AW+DW-1:0] exp_wr;
                    exp_wr = wr_q.pop_front();
                    if ({mem_waddr, mem_wdata} !== exp_wr) begin
                        errors++;
                        $display("FAIL wr_data: got addr=%0d data=%02h, required addr=%0d data=%02h",
                                 mem_waddr, mem_wdata, exp_wr[AW+DW-1:DW], exp_wr[DW-1:0]);
                    end else begin
                        $display("write addr=%0d data=%02h ok", mem_waddr, mem_wdata);
                    end
                end
            end
            if (start_pulse === 1'b1) begin
                checks++;
                if (start_q.size() == 0) begin
                    errors++;
                    $display("FAIL start_unexpected: got start_pulse at cycle %0d, required none", cyc);
                end else begin
                    int exp_c;
                    exp_c = start_q.pop_front();
                    if (cyc != exp_c) begin
                        errors++;
                        $display("FAIL start_cycle: got cycle %0d, required %0d", cyc, exp_c);
                    end else begin
                        $display("start_pulse at cycle %0d ok", cyc);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    // Present one byte; caller sits just after a falling edge. Ready is read
    // before the rising edge, so a handshake happened iff it was 1.
    task automatic send(input logic [7:0] b);
        bit done;
        done    = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        for (int n = 0; n < 64 && !done; n++) begin
            done = (s_ready === 1'b1);
            @(negedge clk_50);
        end
        s_valid = 1'b0;
        hs_cyc  = cyc;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %02h not accepted, required accept within 64 cycles", b);
        end
    endtask

    task automatic send_frame(input logic [7:0] w, input logic [7:0] h, input logic [7:0] s,
                              input logic [7:0] base, input bit gap, input bit raise_busy,
                              input bit expect_start);
        logic [7:0] x;
        int         n;
        n = int'(w) * int'(h);
        x = 8'hA5 ^ w ^ h ^ s;
        send(8'hA5);
        send(w);
        send(h);
        send(s);
        if (raise_busy) begin
            core_busy    = 1'b1;
            clear_active = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            wr_q.push_back({AW'(i), 8'(base + i)});
            x = x ^ 8'(base + i);
            send(8'(base + i));
            if (gap) @(negedge clk_50);
        end
`ifdef IMG_LOADER_CHKSUM_EN
        send(x);
`endif
        if (expect_start) start_q.push_back(hs_cyc + 2);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((wr_q.size() != 0 || start_q.size() != 0) && n < 100) begin
            @(negedge clk_50);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d writes and %0d starts pending, required 0",
                     wr_q.size(), start_q.size());
            wr_q.delete();
            start_q.delete();
        end
        repeat (3) @(negedge clk_50);
    endtask

    task automatic check_reset_values();
        check("rst_s_ready",   32'(s_ready),     32'h0);
        check("rst_mem_we",    32'(mem_we),      32'h0);
        check("rst_start",     32'(start_pulse), 32'h0);
        check("rst_busy",      32'(busy),        32'h0);
        check("rst_err",       32'(err_size),    32'h0);
        check("rst_in_w",      32'(in_w),        32'h0);
        check("rst_in_h",      32'(in_h),        32'h0);
        check("rst_scale",     32'(scale_q),     32'h80);
        check("rst_waddr",     32'(mem_waddr),   32'h0);
        check("rst_wdata",     32'(mem_wdata),   32'h0);
    endtask

    // Bad headers: {W, H, S}
    logic [23:0] bad_hdr [4] = '{24'h01_05_10, 24'h05_01_10, 24'h04_04_00, 24'h41_40_01};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish within 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        s_valid      = 1'b0;
        s_data       = 8'h00;
        core_busy    = 1'b0;
        clear_active = 1'b0;
        repeat (2) @(negedge clk_50);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk_50);
        check("ready_after_release", 32'(s_ready), 32'h1);

        // Basic 3x3 frame, core idle: start 3 cycles after last handshake.
        send_frame(8'd3, 8'd3, 8'h80, 8'h10, 1'b0, 1'b0, 1'b1);
        wait_drain();
        check("f1_in_w",  32'(in_w),     32'h3);
        check("f1_in_h",  32'(in_h),     32'h3);
        check("f1_scale", 32'(scale_q),  32'h80);
        check("f1_busy",  32'(busy),     32'h0);
        check("f1_err",   32'(err_size), 32'h0);

        // Oversize header 80x64 = 5120 > 4096.
        send(8'hA5); send(8'h50); send(8'h40); send(8'h80);
        @(negedge clk_50);
        check("big_err",  32'(err_size), 32'h1);
        check("big_busy", 32'(busy),     32'h0);
        send(8'h11); send(8'h22);
        @(negedge clk_50);
        check("drop_busy", 32'(busy), 32'h0);
        // Other invalid headers, all from ERR.
        foreach (bad_hdr[k]) begin
            logic [23:0] hv;
            hv = bad_hdr[k];
            send(8'hA5); send(hv[23:16]); send(hv[15:8]); send(hv[7:0]);
            @(negedge clk_50);
            check($sformatf("bad_hdr%0d_err", k), 32'(err_size), 32'h1);
        end
        check("hold_in_w",  32'(in_w),    32'h3);
        check("hold_scale", 32'(scale_q), 32'h80);

        // Recovery with a valid 2x2 frame.
        send_frame(8'd2, 8'd2, 8'h40, 8'h01, 1'b0, 1'b0, 1'b1);
        wait_drain();
        check("rec_err",   32'(err_size), 32'h0);
        check("rec_in_w",  32'(in_w),     32'h2);
        check("rec_in_h",  32'(in_h),     32'h2);
        check("rec_scale", 32'(scale_q),  32'h40);

        // Boundary: 64x64 = 4096 exactly fills mem_in.
        send_frame(8'd64, 8'd64, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
        wait_drain();
        check("max_err",  32'(err_size), 32'h0);
        check("max_in_w", 32'(in_w),     32'h40);

        // core_busy in IDLE: not ready, nothing consumed.
        core_busy = 1'b1;
        repeat (2) @(negedge clk_50);
        check("idle_busy_ready", 32'(s_ready), 32'h0);
        s_valid = 1'b1;
        s_data  = 8'hA5;
        repeat (3) @(negedge clk_50);
        check("idle_busy_consumed", 32'(busy), 32'h0);
        s_valid   = 1'b0;
        core_busy = 1'b0;
        repeat (2) @(negedge clk_50);

        // core_busy and clear_active rise during PIX; start waits for both.
        begin
            int m;
            send_frame(8'd2, 8'd3, 8'h60, 8'h50, 1'b0, 1'b1, 1'b0);
            repeat (5) @(negedge clk_50);
            check("wait_busy", 32'(busy), 32'h1);
            core_busy = 1'b0;
            repeat (3) @(negedge clk_50);
            check("wait_clear", 32'(busy), 32'h1);
            clear_active = 1'b0;
            m = cyc;
            start_q.push_back(m + 2);
            wait_drain();
            check("wait_done_busy", 32'(busy), 32'h0);
        end

        // Reset after 4 pixels of a 3x3 frame.
        send(8'hA5); send(8'h03); send(8'h03); send(8'h80);
        for (int i = 0; i < 4; i++) begin
            wr_q.push_back({AW'(i), 8'(8'hC0 + i)});
            send(8'(8'hC0 + i));
        end
        @(negedge clk_50);
        rst_n = 1'b0;
        @(negedge clk_50);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk_50);
        check("rerst_ready", 32'(s_ready), 32'h1);
        send_frame(8'd3, 8'd3, 8'h80, 8'h20, 1'b0, 1'b0, 1'b1);
        wait_drain();
        check("rerst_in_w", 32'(in_w), 32'h3);

        // s_valid toggling every other cycle in PIX.
        send_frame(8'd3, 8'd2, 8'h90, 8'h30, 1'b1, 1'b0, 1'b1);
        wait_drain();
        check("gap_in_h",  32'(in_h),    32'h2);
        check("gap_scale", 32'(scale_q), 32'h90);

`ifdef IMG_LOADER_CHKSUM_EN
        // Good trailer is covered by send_frame; explicit hand value here.
        send(8'hA5); send(8'h02); send(8'h02); send(8'h40);
        for (int i = 0; i < 4; i++) begin
            wr_q.push_back({AW'(i), 8'(i + 1)});
            send(8'(i + 1));
        end
        send(8'hE1);
        start_q.push_back(hs_cyc + 2);
        wait_drain();
        check("chk_good_err", 32'(err_size), 32'h0);
        // Same frame with corrupted trailer: writes happen, no start.
        send(8'hA5); send(8'h02); send(8'h02); send(8'h40);
        for (int i = 0; i < 4; i++) begin
            wr_q.push_back({AW'(i), 8'(i + 1)});
            send(8'(i + 1));
        end
        send(8'hE0);
        wait_drain();
        check("chk_bad_err",  32'(err_size), 32'h1);
        check("chk_bad_busy", 32'(busy),     32'h0);
`endif

        check("end_wr_q",    32'(wr_q.size()),    32'h0);
        check("end_start_q", 32'(start_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
